erx_pkt_decode: RTL and testbench



---
 rtl/erx_pkt_decode_pkg.sv | 44 ++++
 rtl/erx_pkt_decode_fifo.sv | 82 ++++++++
 rtl/erx_pkt_decode.sv | 155 +++++++++++++++
 tb/tb_erx_pkt_decode.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/erx_pkt_decode_pkg.sv
// ----------------------------------------------------------------------------
// erx_pkt_decode_pkg
// Shared definitions for the elink RX packet decode slice: bit positions of
// each field in a 104-bit emesh packet, datamode encodings, and the helper
// that turns a datamode into the address stride of a burst continuation.
// ----------------------------------------------------------------------------
package erx_pkt_decode_pkg;

    // emesh packet field positions
    localparam int ACCESS       = 0;
    localparam int WRITE        = 1;
    localparam int DATAMODE_LSB = 2;
    localparam int DATAMODE_MSB = 3;
    localparam int CTRLMODE_LSB = 4;
    localparam int CTRLMODE_MSB = 7;
    localparam int DSTADDR_LSB  = 8;
    localparam int DSTADDR_MSB  = 39;
    localparam int DATA_LSB     = 40;
    localparam int DATA_MSB     = 71;
    localparam int SRCADDR_LSB  = 72;
    localparam int SRCADDR_MSB  = 103;

    typedef enum logic [1:0] {
        BYTE   = 2'd0,
        HALF   = 2'd1,
        WORD   = 2'd2,
        DOUBLE = 2'd3
    } datamode_e;

    // Address step from one burst beat to the next: the transfer size in
    // bytes when the burst increments, otherwise zero (fixed address).
    function automatic logic [31:0] burst_stride(input logic [1:0] datamode,
                                                 input logic       incr);
        logic [31:0] size;
        case (datamode_e'(datamode))
            BYTE:    size = 32'd1;
            HALF:    size = 32'd2;
            WORD:    size = 32'd4;
            default: size = 32'd8;
        endcase
        return incr ? size : 32'd0;
    endfunction

endpackage

// File: rtl/erx_pkt_decode_fifo.sv
// ----------------------------------------------------------------------------
// erx_pkt_fifo
// Synchronous show-ahead FIFO. head_data is the oldest entry and stays stable
// until it is popped. A push is accepted when the FIFO is not full, or when it
// is full but a pop happens on the same edge. A push that cannot be accepted is
// dropped and flagged on 'dropped' for that cycle. Pops while empty are ignored.
//
// Ports:
//   rx_lclk_div4  clock
//   reset         synchronous active-high reset (empties the FIFO)
//   push          write request, push_data [PW] is the entry
//   pop           read request for the current head
//   head_data     [PW] current head entry (valid when count != 0)
//   count         [CW] current occupancy
//   count_next    [CW] occupancy after this edge
//   dropped       push refused this cycle because the FIFO is full
// ----------------------------------------------------------------------------
module erx_pkt_fifo #(
    parameter  int PW    = 104,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          rx_lclk_div4,
    input  logic          reset,
    input  logic          push,
    input  logic [PW-1:0] push_data,
    input  logic          pop,
    output logic [PW-1:0] head_data,
    output logic [CW-1:0] count,
    output logic [CW-1:0] count_next,
    output logic          dropped
);

    logic [PW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          pop_ok;
    logic          push_ok;

    // Full is judged after the pop, so a full FIFO still takes a push when it
    // is being read on the same edge.
    assign pop_ok    = pop && (count != '0);
    assign push_ok   = push && ((count != CW'(DEPTH)) || pop_ok);
    assign dropped   = push && !push_ok;
    assign head_data = mem[rd_ptr];

    always_comb begin
        // NOTE: assign the default before the case so every path drives
        // count_next; a missing default would infer a latch.
        count_next = count;
        case ({push_ok, pop_ok})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    // NOTE: storage has no reset; validity is carried by count and the
    // pointers, so resetting the array would only add reset fan-out.
    always_ff @(posedge rx_lclk_div4) begin
        if (push_ok)
            mem[wr_ptr] <= push_data;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge rx_lclk_div4) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + AW'(1);   // power-of-2 depth: natural wrap
            if (pop_ok)
                rd_ptr <= rd_ptr + AW'(1);
            count <= count_next;
        end
    end

endmodule

// File: rtl/erx_pkt_decode.sv
// ----------------------------------------------------------------------------
// erx_pkt_decode
// Sits behind the elink RX I/O stage in the rx_lclk_div4 domain. The I/O stage
// leaves dstaddr stale on burst continuation packets; a one-register fix stage
// rebuilds it from the last base address. Fixed packets are buffered in a
// show-ahead FIFO feeding the erx core, and FIFO occupancy drives the write and
// read pushback signals back to the I/O stage.
//
// Latency: a packet presented before edge N is held in the fix stage after
// edge N and reaches the FIFO head (out_access=1) after edge N+1, i.e. two
// edges after it was applied, when the FIFO is empty.
//
// Ports:
//   rx_lclk_div4        clock
//   reset               synchronous active-high reset
//   in_access           packet valid (no per-cycle backpressure)
//   in_burst            packet is a burst continuation
//   in_burst_incr_addr  continuation advances dstaddr by the transfer size
//   in_packet [PW]      emesh packet
//   out_access          FIFO head valid
//   out_packet [PW]     FIFO head packet
//   out_wait            consumer stall; head is held while set
//   rx_wr_wait          write pushback, count >= DEPTH-MARGIN
//   rx_rd_wait          read pushback, count >= DEPTH-MARGIN-1
//   overflow_err        sticky, a packet was dropped on a full FIFO
//   burst_err           sticky, a continuation arrived with no burst base
//
// Optional feature, macro ERX_PKT_DECODE_STATS_EN:
//   stat_pkts  [16]     accepted FIFO pushes, saturating
//   stat_drops [16]     overflow drops, saturating
// ----------------------------------------------------------------------------
module erx_pkt_decode
    import erx_pkt_decode_pkg::*;
#(
    parameter int PW     = 104,
    parameter int DEPTH  = 8,
    parameter int MARGIN = 3
) (
    input  logic          rx_lclk_div4,
    input  logic          reset,
    input  logic          in_access,
    input  logic          in_burst,
    input  logic          in_burst_incr_addr,
    input  logic [PW-1:0] in_packet,
    output logic          out_access,
    output logic [PW-1:0] out_packet,
    input  logic          out_wait,
    output logic          rx_wr_wait,
    output logic          rx_rd_wait,
    output logic          overflow_err,
    output logic          burst_err
`ifdef ERX_PKT_DECODE_STATS_EN
   ,output logic [15:0]   stat_pkts,
    output logic [15:0]   stat_drops
`endif
);

    localparam int            CW       = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] WR_LEVEL = CW'(DEPTH - MARGIN);
    localparam logic [CW-1:0] RD_LEVEL = CW'(DEPTH - MARGIN - 1);

    logic          fix_valid;
    logic [PW-1:0] fix_packet;
    logic          base_valid;
    logic [31:0]   base_addr;
    logic [31:0]   next_addr;
    logic [PW-1:0] fixed_packet;

    logic          fifo_pop;
    logic          fifo_dropped;
    logic [CW-1:0] fifo_count;
    logic [CW-1:0] fifo_count_next;

    // Address rebuild: only a continuation that has a base gets its dstaddr
    // replaced; 32-bit arithmetic gives the mod 2^32 wrap.
    always_comb begin
        next_addr    = base_addr + burst_stride(in_packet[DATAMODE_MSB:DATAMODE_LSB],
                                                in_burst_incr_addr);
        fixed_packet = in_packet;
        if (in_burst && base_valid)
            fixed_packet[DSTADDR_MSB:DSTADDR_LSB] = next_addr;
    end

    always_ff @(posedge rx_lclk_div4) begin
        if (reset) begin
            fix_valid  <= 1'b0;
            fix_packet <= '0;
            base_valid <= 1'b0;
            base_addr  <= '0;
            burst_err  <= 1'b0;
        end else begin
            fix_valid <= in_access;
            if (in_access) begin
                fix_packet <= fixed_packet;
                if (!in_burst) begin
                    base_addr  <= in_packet[DSTADDR_MSB:DSTADDR_LSB];
                    base_valid <= 1'b1;
                end else if (base_valid) begin
                    base_addr  <= next_addr;
                end else begin
                    burst_err  <= 1'b1;
                end
            end
        end
    end

    assign out_access = (fifo_count != '0);
    assign fifo_pop   = out_access && !out_wait;

    erx_pkt_fifo #(
        .PW    (PW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .rx_lclk_div4 (rx_lclk_div4),
        .reset        (reset),
        .push         (fix_valid),
        .push_data    (fix_packet),
        .pop          (fifo_pop),
        .head_data    (out_packet),
        .count        (fifo_count),
        .count_next   (fifo_count_next),
        .dropped      (fifo_dropped)
    );

    // Pushback is registered from the next-state count so it lines up with the
    // occupancy the FIFO holds after this edge. Reads assert one entry early
    // because each read spawns a response that needs room.
    always_ff @(posedge rx_lclk_div4) begin
        if (reset) begin
            rx_wr_wait   <= 1'b0;
            rx_rd_wait   <= 1'b0;
            overflow_err <= 1'b0;
        end else begin
            rx_wr_wait <= (fifo_count_next >= WR_LEVEL);
            rx_rd_wait <= (fifo_count_next >= RD_LEVEL);
            if (fifo_dropped)
                overflow_err <= 1'b1;
        end
    end

`ifdef ERX_PKT_DECODE_STATS_EN
    always_ff @(posedge rx_lclk_div4) begin
        if (reset) begin
            stat_pkts  <= '0;
            stat_drops <= '0;
        end else begin
            if (fix_valid && !fifo_dropped && (stat_pkts != 16'hFFFF))
                stat_pkts <= stat_pkts + 16'd1;
            if (fifo_dropped && (stat_drops != 16'hFFFF))
                stat_drops <= stat_drops + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_erx_pkt_decode.sv
// ----------------------------------------------------------------------------
// tb_erx_pkt_decode
// Reference model tracks FIFO occupancy as a plain integer and the expected
// output stream as a queue; a negedge monitor compares the DUT against it.
// ----------------------------------------------------------------------------
module tb_erx_pkt_decode;

    localparam int PW     = 104;
    localparam int DEPTH  = 8;
    localparam int MARGIN = 3;

    logic          rx_lclk_div4 = 1'b0;
    logic          reset = 1'b1;
    logic          in_access = 1'b0;
    logic          in_burst = 1'b0;
    logic          in_burst_incr_addr = 1'b0;
    logic [PW-1:0] in_packet = '0;
    logic          out_wait = 1'b0;
    logic          out_access;
    logic [PW-1:0] out_packet;
    logic          rx_wr_wait;
    logic          rx_rd_wait;
    logic          overflow_err;
    logic          burst_err;
`ifdef ERX_PKT_DECODE_STATS_EN
    logic [15:0]   stat_pkts;
    logic [15:0]   stat_drops;
`endif

    always #5 rx_lclk_div4 = ~rx_lclk_div4;

    erx_pkt_decode #(.PW(PW), .DEPTH(DEPTH), .MARGIN(MARGIN)) dut (
        .rx_lclk_div4       (rx_lclk_div4),
        .reset              (reset),
        .in_access          (in_access),
        .in_burst           (in_burst),
        .in_burst_incr_addr (in_burst_incr_addr),
        .in_packet          (in_packet),
        .out_access         (out_access),
        .out_packet         (out_packet),
        .out_wait           (out_wait),
        .rx_wr_wait         (rx_wr_wait),
        .rx_rd_wait         (rx_rd_wait),
        .overflow_err       (overflow_err),
        .burst_err          (burst_err)
`ifdef ERX_PKT_DECODE_STATS_EN
       ,.stat_pkts          (stat_pkts),
        .stat_drops         (stat_drops)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [PW-1:0] sb[$];          // expected FIFO contents, oldest first
    logic [31:0]   obs_addr[$];    // dstaddr of packets the DUT delivered
    logic [31:0]   obs_data[$];    // data field of packets the DUT delivered
    int            m_count = 0;
    bit            m_stage_valid = 0;
    logic [PW-1:0] m_stage = '0;
    bit            m_base_valid = 0;
    logic [31:0]   m_base = '0;
    bit            m_burst_err = 0;
    bit            m_ovf = 0;
    int            m_pkts = 0;
    int            m_drops = 0;
    logic [PW-1:0] m_pkt;
    logic [1:0]    m_dm;
    bit            mon_en = 0;

    always @(posedge rx_lclk_div4) begin
        if (reset) begin
            sb.delete();
            m_count = 0; m_stage_valid = 0; m_base_valid = 0; m_base = '0;
            m_burst_err = 0; m_ovf = 0; m_pkts = 0; m_drops = 0;
        end else begin
            if (m_count > 0 && !out_wait)
                m_count--;
            if (m_stage_valid) begin
                if (m_count < DEPTH) begin
                    m_count++;
                    sb.push_back(m_stage);
                    if (m_pkts < 65535) m_pkts++;
                end else begin
                    m_ovf = 1;
                    if (m_drops < 65535) m_drops++;
                end
            end
            m_stage_valid = in_access;
            if (in_access) begin
                m_pkt = in_packet;
                m_dm  = m_pkt[3:2];
                if (!in_burst) begin
                    m_base = m_pkt[39:8];
                    m_base_valid = 1;
                end else if (m_base_valid) begin
                    m_base = m_base + (in_burst_incr_addr ? (32'd1 << m_dm) : 32'd0);
                    m_pkt[39:8] = m_base;
                end else begin
                    m_burst_err = 1;
                end
                m_stage = m_pkt;
            end
        end
    end

    // ---------------- monitor ----------------
    always @(negedge rx_lclk_div4) begin
        if (mon_en) begin
            check("out_access", PW'(out_access), PW'(m_count > 0));
            check("rx_rd_wait", PW'(rx_rd_wait), PW'(m_count >= DEPTH - MARGIN - 1));
            check("rx_wr_wait", PW'(rx_wr_wait), PW'(m_count >= DEPTH - MARGIN));
            check("overflow_err", PW'(overflow_err), PW'(m_ovf));
            check("burst_err", PW'(burst_err), PW'(m_burst_err));
`ifdef ERX_PKT_DECODE_STATS_EN
            check("stat_pkts", PW'(stat_pkts), PW'(m_pkts));
            check("stat_drops", PW'(stat_drops), PW'(m_drops));
`endif
            if (out_access && !out_wait) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL out_packet: got unexpected %h expected no packet at %0t", out_packet, $time);
                end else begin
                    check("out_packet", out_packet, sb.pop_front());
                    obs_addr.push_back(out_packet[39:8]);
                    obs_data.push_back(out_packet[71:40]);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input bit acc, input bit burst, input bit incr,
                         input logic [31:0] dst, input logic [1:0] dm, input logic [31:0] data);
        in_access = acc;
        in_burst = burst;
        in_burst_incr_addr = incr;
        in_packet = {data ^ 32'h5a5a_0f0f, data, dst, 4'h3, dm, 1'b1, acc};
        @(posedge rx_lclk_div4); #1;
        in_access = 0;
        in_burst = 0;
        in_burst_incr_addr = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge rx_lclk_div4); #1; end
    endtask

    task automatic pulse_reset();
        reset = 1;
        @(posedge rx_lclk_div4); #1;
        reset = 0;
    endtask

    task automatic drain();
        int n = 0;
        out_wait = 0;
        while ((m_count != 0 || m_stage_valid) && n < 200) begin
            @(posedge rx_lclk_div4); #1;
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got count %0d expected 0", m_count);
        end
    endtask

    logic [PW-1:0] sent;
    logic [31:0]   exp_b[4] = '{32'h1000, 32'h1008, 32'h1010, 32'h1018};
    logic [31:0]   exp_w[4] = '{32'h2000, 32'h2000, 32'hFFFF_FFF8, 32'h0000_0000};

    initial begin
        // reset state
        idle(1);
        mon_en = 1;
        idle(2);
        check("reset_out_access", PW'(out_access), '0);
        check("reset_wr_wait", PW'(rx_wr_wait), '0);
        reset = 0;
        idle(2);

        // single write: latency and bit-identical passthrough
        drive(1, 0, 0, 32'h8080_0000, 2'd2, 32'hCAFE_0001);
        sent = in_packet;
        check("lat_edge1", PW'(out_access), '0);
        idle(1);
        check("lat_edge2", PW'(out_access), PW'(1'b1));
        check("single_packet", out_packet, sent);
        idle(1);
        check("single_one_cycle", PW'(out_access), '0);
        drain();

        // incrementing burst with stale dstaddr
        obs_addr.delete();
        drive(1, 0, 0, 32'h0000_1000, 2'd3, 32'h1);
        for (int i = 0; i < 3; i++) drive(1, 1, 1, 32'hDEAD_0000, 2'd3, 32'h2 + i);
        drain();
        check("burst_len", PW'(obs_addr.size()), PW'(4));
        for (int i = 0; i < 4 && i < obs_addr.size(); i++)
            check("burst_addr", PW'(obs_addr[i]), PW'(exp_b[i]));

        // fixed-address continuation and 32-bit wrap
        obs_addr.delete();
        drive(1, 0, 0, 32'h0000_2000, 2'd2, 32'h10);
        drive(1, 1, 0, 32'hDEAD_0000, 2'd2, 32'h11);
        drive(1, 0, 0, 32'hFFFF_FFF8, 2'd3, 32'h12);
        drive(1, 1, 1, 32'hDEAD_0000, 2'd3, 32'h13);
        drain();
        check("wrap_len", PW'(obs_addr.size()), PW'(4));
        for (int i = 0; i < 4 && i < obs_addr.size(); i++)
            check("wrap_addr", PW'(obs_addr[i]), PW'(exp_w[i]));

        // continuation first after reset
        pulse_reset();
        obs_addr.delete();
        drive(1, 1, 1, 32'h0000_3000, 2'd2, 32'h20);
        check("burst_err_set", PW'(burst_err), PW'(1'b1));
        drive(1, 0, 0, 32'h0000_4000, 2'd2, 32'h21);
        drain();
        idle(3);
        check("burst_err_sticky", PW'(burst_err), PW'(1'b1));
        if (obs_addr.size() > 0) check("burst_err_passthru", PW'(obs_addr[0]), PW'(32'h3000));
        else check("burst_err_passthru", '0, PW'(32'h3000));

        // fill with consumer stalled: thresholds, drops, ordering
        pulse_reset();
        obs_data.delete();
        out_wait = 1;
        for (int i = 1; i <= 10; i++) begin
            drive(1, 0, 0, 32'h100 * i, 2'd2, i);
            check("fill_rd_wait", PW'(rx_rd_wait), PW'(((i - 1 > 8) ? 8 : i - 1) >= 4));
            check("fill_wr_wait", PW'(rx_wr_wait), PW'(((i - 1 > 8) ? 8 : i - 1) >= 5));
        end
        idle(1);
        check("fill_overflow", PW'(overflow_err), PW'(1'b1));
        drain();
        check("fill_len", PW'(obs_data.size()), PW'(8));
        for (int i = 0; i < 8 && i < obs_data.size(); i++)
            check("fill_order", PW'(obs_data[i]), PW'(i + 1));

        // full FIFO with simultaneous push and pop
        pulse_reset();
        obs_data.delete();
        out_wait = 1;
        for (int i = 1; i <= 9; i++) drive(1, 0, 0, 32'h200 * i, 2'd1, i);
        out_wait = 0;
        idle(1);
        out_wait = 1;
        check("full_pp_wr_wait", PW'(rx_wr_wait), PW'(1'b1));
        check("full_pp_no_ovf", PW'(overflow_err), '0);
        drain();
        check("full_pp_len", PW'(obs_data.size()), PW'(9));

        // reset in the middle of a stalled burst
        out_wait = 1;
        drive(1, 0, 0, 32'h0000_5000, 2'd2, 32'h30);
        for (int i = 0; i < 5; i++) drive(1, 1, 1, 32'hDEAD_0000, 2'd2, 32'h31 + i);
        pulse_reset();
        check("midrst_out_access", PW'(out_access), '0);
        check("midrst_wr_wait", PW'(rx_wr_wait), '0);
        check("midrst_rd_wait", PW'(rx_rd_wait), '0);
        out_wait = 0;
        drive(1, 1, 1, 32'hDEAD_0000, 2'd2, 32'h40);
        check("midrst_burst_err", PW'(burst_err), PW'(1'b1));
        drain();

        // randomized traffic
        pulse_reset();
        for (int c = 0; c < 3000; c++) begin
            out_wait = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 499) == 0) begin
                pulse_reset();
            end else begin
                drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                      $urandom_range(0, 1) == 1, $urandom, 2'($urandom_range(0, 3)), $urandom);
            end
        end
        drain();
        check("sb_empty", PW'(sb.size()), '0);

        mon_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
